// File: rtl/contador_btn_cond_if.sv
// Button-conditioner bus: raw buttons and enable in, count pulses and held flags out.
// Latency: none, wiring only.
// Backpressure: none; pulses are fire-and-forget requests to the counter core.
interface contador_btn_cond_if;
  logic ena;
  logic btn_up;
  logic btn_down;
  logic up_pulse;
  logic down_pulse;
  logic up_held;
  logic down_held;

  // Drives enable and buttons, observes the conditioned outputs.
  modport master (
    output ena, btn_up, btn_down,
    input  up_pulse, down_pulse, up_held, down_held
  );

  // The conditioner itself.
  modport slave (
    input  ena, btn_up, btn_down,
    output up_pulse, down_pulse, up_held, down_held
  );
endinterface

// File: rtl/contador_btn_cond.sv
// Two-channel push-button conditioner: sync, debounce, optional auto-repeat.
// Latency: press pulse in the cycle after edge k+2+DEB_CYCLES (k = first edge sampling btn high).
// Backpressure: none; the counter core must take every one-cycle pulse.
module contador_btn_cond #(
  parameter int CNT_W      = 20,
  parameter int DEB_CYCLES = 50000,
  parameter int RPT_EN     = 1,
  parameter int RPT_DELAY  = 500000,
  parameter int RPT_PERIOD = 100000
) (
  input  logic                clk,
  input  logic                rst,
  contador_btn_cond_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  // Per-channel state: FSM state, shared debounce/repeat timer, and a flag
  // selecting the long first-repeat delay over the shorter repeat period.
  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] t;
    logic             first;
  } chan_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

  // Next state of one channel given its synchronized button level; raw_o is
  // the unfiltered count request before up/down collision suppression.
  function automatic chan_t chan_next(input chan_t cur, input logic s2, output logic raw_o);
    chan_t nx;
    nx    = cur;
    raw_o = 1'b0;
    case (cur.st)
      IDLE: begin
        if (s2) begin
          nx.st = DEB_PRESS;
          nx.t  = '0;
        end
      end
      DEB_PRESS: begin
        if (!s2) begin
          nx.st = IDLE;
          nx.t  = '0;
        end else if (cur.t == DEB_LAST) begin
          nx.st    = PRESSED;
          nx.t     = '0;
          nx.first = 1'b1;
          raw_o    = 1'b1;
        end else begin
          nx.t = cur.t + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          nx.st = DEB_REL;
          nx.t  = '0;
        end else if (RPT_EN != 0) begin
          if (cur.t == (cur.first ? DLY_LAST : PER_LAST)) begin
            nx.t     = '0;
            nx.first = 1'b0;
            raw_o    = 1'b1;
          end else begin
            nx.t = cur.t + 1'b1;
          end
        end
      end
      DEB_REL: begin
        // A bounce back high resumes the press without a new count, but the
        // auto-repeat schedule starts over from the long delay.
        if (s2) begin
          nx.st    = PRESSED;
          nx.t     = '0;
          nx.first = 1'b1;
        end else if (cur.t == DEB_LAST) begin
          nx.st = IDLE;
          nx.t  = '0;
        end else begin
          nx.t = cur.t + 1'b1;
        end
      end
      default: begin
        nx.st = IDLE;
        nx.t  = '0;
      end
    endcase
    return nx;
  endfunction

  // Bit 0 = up channel, bit 1 = down channel.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  chan_t      up_q, up_d;
  chan_t      dn_q, dn_d;
  logic       up_raw, dn_raw;
  logic       up_pulse_q, down_pulse_q;
  logic       up_held_q, down_held_q;

  // Combinational next state for both channel FSMs.
  always_comb begin
    up_raw = 1'b0;
    dn_raw = 1'b0;
    up_d   = chan_next(up_q, sync2_q[0], up_raw);
    dn_d   = chan_next(dn_q, sync2_q[1], dn_raw);
  end

  // Synchronizers, both FSMs and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      up_q         <= '0;
      dn_q         <= '0;
      up_pulse_q   <= 1'b0;
      down_pulse_q <= 1'b0;
      up_held_q    <= 1'b0;
      down_held_q  <= 1'b0;
    end else begin
      // Synchronizers keep tracking the pins while disabled, so a re-enable
      // sees the real button level immediately.
      sync1_q <= {bus.btn_down, bus.btn_up};
      sync2_q <= sync1_q;
      if (!bus.ena) begin
        up_q         <= '0;
        dn_q         <= '0;
        up_pulse_q   <= 1'b0;
        down_pulse_q <= 1'b0;
        up_held_q    <= 1'b0;
        down_held_q  <= 1'b0;
      end else begin
        up_q         <= up_d;
        dn_q         <= dn_d;
        // Coincident up and down requests cancel: the net count is zero.
        up_pulse_q   <= up_raw & ~dn_raw;
        down_pulse_q <= dn_raw & ~up_raw;
        up_held_q    <= (up_d.st == PRESSED) || (up_d.st == DEB_REL);
        down_held_q  <= (dn_d.st == PRESSED) || (dn_d.st == DEB_REL);
      end
    end
  end

  assign bus.up_pulse   = up_pulse_q;
  assign bus.down_pulse = down_pulse_q;
  assign bus.up_held    = up_held_q;
  assign bus.down_held  = down_held_q;

endmodule
